// File: rtl/normalize_left_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : normalize_left_pkg
//  Purpose  : Floating-point constants shared by the adder datapath stages
//             (right-shift alignment, post-add normalizer): field widths,
//             exponent limits and the normalizer state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package normalize_left_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    // All-ones exponent encodes Inf/NaN; the largest finite exponent is one less.
    localparam logic [EXP_W-1:0] EXP_MAX        = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_MAX_FINITE = {{(EXP_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : normalize_left_pkg
`default_nettype wire

// File: rtl/normalize_left_shiftLeft.sv
`default_nettype none
// ============================================================================
//  Module   : shiftLeft
//  Purpose  : One left-normalization step: mantissa shifted left by one,
//             exponent decremented by one. Purely combinational.
//  Ports    : mantCur     - {carry, hidden, fraction} before the step
//             expCur      - biased exponent before the step
//             mantShifted - mantissa after the step
//             expDec      - exponent after the step
//  Revision : 1.0 - initial release
// ============================================================================
module shiftLeft #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic [FRAC_W+1:0] mantCur,
    input  logic [EXP_W-1:0]  expCur,
    output logic [FRAC_W+1:0] mantShifted,
    output logic [EXP_W-1:0]  expDec
);

    localparam logic [EXP_W-1:0] c_expOne = {{(EXP_W-1){1'b0}}, 1'b1};

    // Only used while carry is clear, so dropping the top bit loses nothing.
    assign mantShifted = {mantCur[FRAC_W:0], 1'b0};
    assign expDec      = expCur - c_expOne;

endmodule : shiftLeft
`default_nettype wire

// File: rtl/normalize_left.sv
`default_nettype none
// ============================================================================
//  Module   : normalize_left
//  Purpose  : Post-add normalizer. Takes the raw mantissa-adder sum and the
//             larger operand's exponent, normalizes one bit per cycle and
//             returns a packed sign/exponent/fraction with zero and
//             overflow flags through a valid/ready handshake.
//  Ports    : clk, rstN (sync, active-low)
//             inValid/inReady   - upstream handshake (inReady only in IDLE)
//             mantIn            - {carry, hidden, fraction} sum magnitude
//             expIn, signIn     - biased exponent and sign of the result
//             outValid/outReady - downstream handshake (outValid only in DONE)
//             fracOut, expOut, signOut, zeroOut, overflowOut - result
//  Revision : 1.0 - initial release
// ============================================================================
module normalize_left
    import normalize_left_pkg::*;
#(
    parameter int EXP_W  = normalize_left_pkg::EXP_W,
    parameter int FRAC_W = normalize_left_pkg::FRAC_W
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              inValid,
    output logic              inReady,
    input  logic [FRAC_W+1:0] mantIn,
    input  logic [EXP_W-1:0]  expIn,
    input  logic              signIn,
    output logic              outValid,
    input  logic              outReady,
    output logic [FRAC_W-1:0] fracOut,
    output logic [EXP_W-1:0]  expOut,
    output logic              signOut,
    output logic              zeroOut,
    output logic              overflowOut
);

    localparam logic [EXP_W-1:0] c_expMax       = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] c_expMaxFinite = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [EXP_W-1:0] c_expOne       = {{(EXP_W-1){1'b0}}, 1'b1};

    state_t             r_state,    w_stateNext;
    logic [FRAC_W+1:0]  r_mant,     w_mantNext;
    logic [EXP_W-1:0]   r_exp,      w_expNext;
    logic               r_sign,     w_signNext;
    logic               r_zero,     w_zeroNext;
    logic               r_ovf,      w_ovfNext;
    logic               r_inReady,  w_inReadyNext;
    logic               r_outValid, w_outValidNext;

    logic [FRAC_W+1:0]  w_mantShl;
    logic [EXP_W-1:0]   w_expShl;

    shiftLeft #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_shiftLeft (
        .mantCur     (r_mant),
        .expCur      (r_exp),
        .mantShifted (w_mantShl),
        .expDec      (w_expShl)
    );

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state    <= IDLE;
            r_mant     <= '0;
            r_exp      <= '0;
            r_sign     <= 1'b0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
            r_inReady  <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_mant     <= w_mantNext;
            r_exp      <= w_expNext;
            r_sign     <= w_signNext;
            r_zero     <= w_zeroNext;
            r_ovf      <= w_ovfNext;
            r_inReady  <= w_inReadyNext;
            r_outValid <= w_outValidNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_mantNext     = r_mant;
        w_expNext      = r_exp;
        w_signNext     = r_sign;
        w_zeroNext     = r_zero;
        w_ovfNext      = r_ovf;
        w_outValidNext = 1'b0;

        case (r_state)
            IDLE: begin
                // r_inReady is low for the first cycle after reset, so the
                // handshake (not just the state) gates the load.
                if (inValid && r_inReady) begin
                    w_mantNext  = mantIn;
                    w_expNext   = expIn;
                    w_signNext  = signIn;
                    w_zeroNext  = 1'b0;
                    w_ovfNext   = 1'b0;
                    w_stateNext = NORM;
                end
            end

            NORM: begin
                if (r_mant[FRAC_W+1]) begin
                    // Carry-out: one right shift, LSB truncated.
                    w_mantNext  = {1'b0, r_mant[FRAC_W+1:1]};
                    // >= also catches an out-of-range all-ones input exponent
                    // so the increment can never wrap.
                    if (r_exp >= c_expMaxFinite) begin
                        w_expNext  = c_expMax;
                        w_mantNext = '0;
                        w_ovfNext  = 1'b1;
                    end else begin
                        w_expNext  = r_exp + c_expOne;
                    end
                    w_stateNext = DONE;
                end else if (r_mant == '0) begin
                    w_expNext   = '0;
                    w_zeroNext  = 1'b1;
                    w_stateNext = DONE;
                end else if (r_mant[FRAC_W]) begin
                    // Two denormals can sum into the normal range.
                    if (r_exp == '0) begin
                        w_expNext = c_expOne;
                    end
                    w_stateNext = DONE;
                end else if (r_exp <= c_expOne) begin
                    // No exponent left to borrow: result stays denormal.
                    w_expNext   = '0;
                    w_stateNext = DONE;
                end else begin
                    w_mantNext  = w_mantShl;
                    w_expNext   = w_expShl;
                end
            end

            DONE: begin
                // outValid rises one cycle after entering DONE; the result
                // registers are untouched here so they hold under backpressure.
                if (r_outValid && outReady) begin
                    w_stateNext = IDLE;
                end else begin
                    w_outValidNext = 1'b1;
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase

        w_inReadyNext = (w_stateNext == IDLE);
    end

    assign inReady     = r_inReady;
    assign outValid    = r_outValid;
    assign fracOut     = r_mant[FRAC_W-1:0];
    assign expOut      = r_exp;
    assign signOut     = r_sign;
    assign zeroOut     = r_zero;
    assign overflowOut = r_ovf;

endmodule : normalize_left
`default_nettype wire

// File: tb/tb_normalize_left.sv
`default_nettype none
// ============================================================================
//  Module   : tb_normalize_left
//  Purpose  : Scoreboard bench for normalize_left. The driver pushes the
//             hand-computed result of each transaction; a monitor pops and
//             compares whenever outValid rises, and checks hold stability.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_normalize_left;

    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic [24:0] mantIn;
    logic [7:0]  expIn;
    logic        signIn;
    logic        outValid;
    logic        outReady;
    logic [22:0] fracOut;
    logic [7:0]  expOut;
    logic        signOut;
    logic        zeroOut;
    logic        overflowOut;

    normalize_left #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .inValid     (inValid),
        .inReady     (inReady),
        .mantIn      (mantIn),
        .expIn       (expIn),
        .signIn      (signIn),
        .outValid    (outValid),
        .outReady    (outReady),
        .fracOut     (fracOut),
        .expOut      (expOut),
        .signOut     (signOut),
        .zeroOut     (zeroOut),
        .overflowOut (overflowOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] mant;
        logic [7:0]  expI;
        logic        sign;
        logic [22:0] frac;
        logic [7:0]  expO;
        logic        zero;
        logic        ovf;
        int          lat;
        int          acceptEdge;
    } txn_t;

    txn_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic        prevValid = 1'b0;
    logic        prevReady = 1'b0;
    logic [33:0] snap;

    always @(negedge clk) begin
        if (!rstN) begin
            prevValid = 1'b0;
        end else begin
            if (outValid && inReady) check("valid_ready_overlap", 1, 0);
            if (overflowOut && zeroOut && outValid) check("flags_exclusive", 1, 0);
            if (outValid && !prevValid) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    txn_t e;
                    e = sb.pop_front();
                    check("fracOut",     fracOut,     e.frac);
                    check("expOut",      expOut,      e.expO);
                    check("signOut",     signOut,     e.sign);
                    check("zeroOut",     zeroOut,     e.zero);
                    check("overflowOut", overflowOut, e.ovf);
                    check("latency",     cyc - e.acceptEdge, e.lat);
                end
                snap = {fracOut, expOut, signOut, zeroOut, overflowOut};
            end else if (prevValid && !prevReady) begin
                check("hold_valid",  outValid, 1);
                check("hold_data",   {fracOut, expOut, signOut, zeroOut, overflowOut}, snap);
                check("hold_inReady", inReady, 0);
            end
            prevValid = outValid;
        end
        prevReady = outReady;
    end

    // ---------------- driver ----------------
    task automatic send(input logic [24:0] m, input logic [7:0] e, input logic s,
                        input logic [22:0] f, input logic [7:0] eo,
                        input logic z, input logic o, input int lat);
        txn_t t;
        int   n = 0;
        while (!inReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!inReady) begin
            check("accept_timeout", 1, 0);
        end else begin
            mantIn  = m;
            expIn   = e;
            signIn  = s;
            inValid = 1'b1;
            t.mant = m; t.expI = e; t.sign = s; t.frac = f; t.expO = eo;
            t.zero = z; t.ovf = o; t.lat = lat; t.acceptEdge = cyc + 1;
            sb.push_back(t);
            @(negedge clk);
            inValid = 1'b0;
        end
    endtask

    task automatic waitDone();
        int n = 0;
        while ((sb.size() != 0 || outValid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || outValid) check("done_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic sawValid;
        rstN = 1'b0; inValid = 1'b0; outReady = 1'b1;
        mantIn = '0; expIn = '0; signIn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_inReady",  inReady,  0);
        check("rst_outValid", outValid, 0);
        check("rst_data", {fracOut, expOut, signOut, zeroOut, overflowOut}, 0);
        rstN = 1'b1;
        @(negedge clk);
        check("inReady_after_rst", inReady, 1);

        // mant, expIn, sign, frac, expOut, zero, ovf, latency
        send(25'h0800000, 8'd127, 1'b1, 23'h000000, 8'd127, 1'b0, 1'b0, 2);  waitDone();
        send(25'h1800000, 8'd127, 1'b0, 23'h400000, 8'd128, 1'b0, 1'b0, 2);  waitDone();
        send(25'h0000001, 8'd127, 1'b0, 23'h000000, 8'd104, 1'b0, 1'b0, 25); waitDone();
        send(25'h0000100, 8'd3,   1'b1, 23'h000400, 8'd0,   1'b0, 1'b0, 4);  waitDone();
        send(25'h0000000, 8'd90,  1'b0, 23'h000000, 8'd0,   1'b1, 1'b0, 2);  waitDone();
        send(25'h1000000, 8'd254, 1'b1, 23'h000000, 8'd255, 1'b0, 1'b1, 2);  waitDone();
        send(25'h0800000, 8'd0,   1'b0, 23'h000000, 8'd1,   1'b0, 1'b0, 2);  waitDone();
        send(25'h0400000, 8'd10,  1'b0, 23'h000000, 8'd9,   1'b0, 1'b0, 3);  waitDone();
        send(25'h1FFFFFF, 8'd100, 1'b1, 23'h7FFFFF, 8'd101, 1'b0, 1'b0, 2);  waitDone();

        // Backpressure: hold outReady low for 5 cycles once valid.
        outReady = 1'b0;
        send(25'h0C00000, 8'd50, 1'b1, 23'h400000, 8'd50, 1'b0, 1'b0, 2);
        begin
            int n = 0;
            while (!outValid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("bp_valid_seen", outValid, 1);
        end
        repeat (5) @(negedge clk);
        outReady = 1'b1;
        @(negedge clk);
        check("bp_release_valid",   outValid, 0);
        check("bp_release_inReady", inReady,  1);
        waitDone();

        // Reset during NORM of the 23-shift case.
        send(25'h0000001, 8'd127, 1'b0, 23'h000000, 8'd104, 1'b0, 1'b0, 25);
        repeat (5) @(negedge clk);
        rstN = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_outValid", outValid, 0);
        check("abort_inReady",  inReady,  0);
        rstN = 1'b1;
        sawValid = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (outValid) sawValid = 1'b1;
        end
        check("abort_no_output", sawValid, 0);
        send(25'h0000001, 8'd127, 1'b1, 23'h000000, 8'd104, 1'b0, 1'b0, 25); waitDone();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_normalize_left
`default_nettype wire
